// File: rtl/uop_queue.sv
// -----------------------------------------------------------------------------
// uop_queue
//   Decoupling FIFO between decode and execute. Decode pushes one uop per
//   cycle, execute pops one per cycle. Execute stalls reach decode only as
//   enq_ready going low. almost_full gives decode/fetch one cycle of warning.
//   flush discards every queued uop.
//
// Ports
//   clk, reset            core clock; synchronous active-high reset
//   flush                 drop all entries; wins over enq/deq in the same cycle
//   enq_valid/enq_uop     uop offered by decode
//   enq_ready             queue can accept (count < DEPTH)
//   deq_valid/deq_uop     oldest entry (deq_uop is 0 when empty)
//   deq_ready             execute consumes the head this cycle
//   count                 occupied entries, 0..DEPTH
//   almost_full           count >= DEPTH-AF_SLACK
//   overflow_err          sticky: enq_valid seen while enq_ready was low
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high and flush is low. enq_ready, deq_valid and deq_uop depend only on
// registered state, so neither side's ready/valid combinationally feeds the
// other; a valid held high with ready low keeps its payload stable.
// -----------------------------------------------------------------------------
module uop_queue #(
  parameter int UOP_WIDTH = 256,
  parameter int DEPTH     = 8,
  parameter int AF_SLACK  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       enq_valid,
  input  logic [UOP_WIDTH-1:0]       enq_uop,
  output logic                       enq_ready,
  output logic                       deq_valid,
  output logic [UOP_WIDTH-1:0]       deq_uop,
  input  logic                       deq_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full,
  output logic                       overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [UOP_WIDTH-1:0] mem_q [DEPTH];
  logic [UOP_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 overflow_err_q, overflow_err_d;

  logic full;
  logic empty;
  logic enq_fire;
  logic deq_fire;

  // Full/empty come only from the count register; pointers alone are
  // ambiguous when they are equal.
  assign full        = (count_q == CNT_W'(DEPTH));
  assign empty       = (count_q == '0);
  assign enq_ready   = !full;
  assign deq_valid   = !empty;
  assign deq_uop     = empty ? '0 : mem_q[rd_ptr_q];
  assign count       = count_q;
  assign almost_full = (count_q >= CNT_W'(DEPTH - AF_SLACK));
  assign overflow_err = overflow_err_q;

  assign enq_fire = enq_valid && enq_ready && !flush;
  assign deq_fire = deq_valid && deq_ready && !flush;

  always_comb begin
    mem_d          = mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    overflow_err_d = overflow_err_q;

    // A rejected offer is recorded even though the uop itself is dropped.
    if (enq_valid && !enq_ready && !flush) begin
      overflow_err_d = 1'b1;
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_fire) begin
        mem_d[wr_ptr_q] = enq_uop;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (deq_fire) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      overflow_err_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      overflow_err_q <= overflow_err_d;
    end
  end

  // Storage is not reset; its contents only matter once count covers them.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Occupancy invariants.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (count_q <= CNT_W'(DEPTH));
      assert ((count_q == '0) == ((wr_ptr_q == rd_ptr_q) && !full));
    end
  end

endmodule

// File: tb/tb_uop_queue.sv
module tb_uop_queue;

  localparam int W     = 256;
  localparam int DEPTH = 8;
  localparam int SLACK = 2;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          enq_valid;
  logic [W-1:0]  enq_uop;
  logic          enq_ready;
  logic          deq_valid;
  logic [W-1:0]  deq_uop;
  logic          deq_ready;
  logic [3:0]    count;
  logic          almost_full;
  logic          overflow_err;

  int checks   = 0;
  int failures = 0;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int           m_count;
  bit           m_ovf;

  uop_queue #(.UOP_WIDTH(W), .DEPTH(DEPTH), .AF_SLACK(SLACK)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .enq_valid    (enq_valid),
    .enq_uop      (enq_uop),
    .enq_ready    (enq_ready),
    .deq_valid    (deq_valid),
    .deq_uop      (deq_uop),
    .deq_ready    (deq_ready),
    .count        (count),
    .almost_full  (almost_full),
    .overflow_err (overflow_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, ".count"},        W'(count),        W'(m_count));
    check({tag, ".enq_ready"},    W'(enq_ready),    W'(m_count < DEPTH));
    check({tag, ".deq_valid"},    W'(deq_valid),    W'(m_count != 0));
    check({tag, ".almost_full"},  W'(almost_full),  W'(m_count >= DEPTH - SLACK));
    check({tag, ".overflow_err"}, W'(overflow_err), W'(m_ovf));
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    flush     = 1'b0;
    enq_valid = 1'b0;
    enq_uop   = '0;
    deq_ready = 1'b0;
    tick();
    reset = 1'b0;
    m_count = 0;
    m_ovf   = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  // Drives one cycle. Before the edge, a dequeue the model expects is checked
  // against the scoreboard head; after the edge the status outputs are checked.
  task automatic cycle(input string tag, input bit ev, input logic [W-1:0] uop,
                       input bit dr, input bit fl);
    bit enq_acc;
    bit deq_acc;
    logic [W-1:0] exp_head;
    enq_valid = ev;
    enq_uop   = uop;
    deq_ready = dr;
    flush     = fl;
    #1;
    enq_acc = ev && (m_count < DEPTH) && !fl;
    deq_acc = dr && (m_count != 0) && !fl;
    check({tag, ".pre_deq_valid"}, W'(deq_valid), W'(m_count != 0));
    if (deq_acc) begin
      exp_head = exp_q.pop_front();
      check({tag, ".deq_uop"}, deq_uop, exp_head);
    end
    if (ev && (m_count == DEPTH) && !fl) m_ovf = 1'b1;
    if (fl) begin
      exp_q.delete();
      m_count = 0;
    end else begin
      if (enq_acc) exp_q.push_back(uop);
      m_count = m_count + int'(enq_acc) - int'(deq_acc);
    end
    tick();
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    flush     = 1'b0;
    check_status(tag);
  endtask

  task automatic drain(input string tag);
    int n;
    n = m_count;
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, '0, 1'b1, 1'b0);
    check({tag, ".empty_uop"}, deq_uop, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    enq_valid = 1'b0;
    enq_uop   = '0;
    deq_ready = 1'b0;
    m_count   = 0;
    m_ovf     = 1'b0;

    // 1: reset values, then three enqueues held at the head
    do_reset();
    check_status("t1_reset");
    check("t1_reset.deq_uop", deq_uop, '0);
    cycle("t1_enq", 1'b1, W'(8'hA1), 1'b0, 1'b0);
    cycle("t1_enq", 1'b1, W'(8'hA2), 1'b0, 1'b0);
    cycle("t1_enq", 1'b1, W'(8'hA3), 1'b0, 1'b0);
    check("t1_head", deq_uop, W'(8'hA1));
    cycle("t1_hold", 1'b0, '0, 1'b0, 1'b0);
    check("t1_head_stable", deq_uop, W'(8'hA1));
    drain("t1_drain");

    // 2: no bypass on an empty queue; pop arrives one cycle later
    cycle("t2_enq", 1'b1, W'(8'h55), 1'b1, 1'b0);
    check("t2_visible", deq_uop, W'(8'h55));
    cycle("t2_deq", 1'b0, '0, 1'b1, 1'b0);
    check("t2_empty", W'(deq_valid), '0);

    // 3: fill, overflow, drain
    for (int i = 1; i <= DEPTH; i++) cycle("t3_fill", 1'b1, W'(i), 1'b0, 1'b0);
    cycle("t3_ovf", 1'b1, W'(9), 1'b0, 1'b0);
    check("t3_ovf_flag", W'(overflow_err), W'(1));
    drain("t3_drain");

    // 4: steady enq+deq at count=4 across pointer wrap, random payloads
    for (int i = 0; i < 4; i++) cycle("t4_prime", 1'b1, W'(32'h400 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] r;
      r = {$urandom(), $urandom(), $urandom(), $urandom(),
           $urandom(), $urandom(), $urandom(), $urandom_range(1, 32'hFFFF)};
      cycle("t4_stream", 1'b1, r, 1'b1, 1'b0);
    end
    check("t4_count", W'(count), W'(4));
    drain("t4_drain");

    // 5: flush beats same-cycle enq and deq
    for (int i = 0; i < 5; i++) cycle("t5_fill", 1'b1, W'(32'h500 + i), 1'b0, 1'b0);
    cycle("t5_flush", 1'b1, W'(32'h5FF), 1'b1, 1'b1);
    check("t5_flush_uop", deq_uop, '0);
    cycle("t5_after", 1'b1, W'(32'h577), 1'b0, 1'b0);
    drain("t5_drain");

    // 6: reset mid-operation with overflow_err still set from test 3
    for (int i = 0; i < 6; i++) cycle("t6_fill", 1'b1, W'(32'h600 + i), 1'b0, 1'b0);
    check("t6_pre_ovf", W'(overflow_err), W'(1));
    do_reset();
    check_status("t6_reset");
    check("t6_reset.deq_uop", deq_uop, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
